// File: rtl/model_algebra_pkg.sv
// Shared types and constants for the matrix algebra library: frame-buffer state
// encoding, data/control fill constants and an address-width helper.
package model_algebra_pkg;

  localparam int unsigned PKG_DATA_SIZE    = 64;
  localparam int unsigned PKG_CONTROL_SIZE = 4;

  localparam logic [PKG_DATA_SIZE-1:0]    ZERO_DATA    = '0;
  localparam logic [PKG_DATA_SIZE-1:0]    ONE_DATA     = PKG_DATA_SIZE'(1);
  localparam logic [PKG_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
  localparam logic [PKG_CONTROL_SIZE-1:0] ONE_CONTROL  = PKG_CONTROL_SIZE'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Never returns less than 1 so single-entry dimensions still get a counter bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/model_matrix_stream_buffer_if.sv
// Element-stream bus of the matrix frame buffer: capture side, replay side,
// frame control and status.
interface model_matrix_stream_buffer_if #(
  parameter int unsigned DATA_SIZE = 64
);

  logic                 START;
  logic                 READY;
  logic                 ERROR;
  logic                 DATA_IN_I_ENABLE;
  logic                 DATA_IN_J_ENABLE;
  logic                 DATA_OUT_I_ENABLE;
  logic                 DATA_OUT_J_ENABLE;
  logic                 DATA_OUT_STALL;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic [DATA_SIZE-1:0] DATA_OUT;

  modport master (
    output START,
    output DATA_IN_I_ENABLE,
    output DATA_IN_J_ENABLE,
    output DATA_OUT_STALL,
    output SIZE_I_IN,
    output SIZE_J_IN,
    output DATA_IN,
    input  READY,
    input  ERROR,
    input  DATA_OUT_I_ENABLE,
    input  DATA_OUT_J_ENABLE,
    input  DATA_OUT
  );

  modport slave (
    input  START,
    input  DATA_IN_I_ENABLE,
    input  DATA_IN_J_ENABLE,
    input  DATA_OUT_STALL,
    input  SIZE_I_IN,
    input  SIZE_J_IN,
    input  DATA_IN,
    output READY,
    output ERROR,
    output DATA_OUT_I_ENABLE,
    output DATA_OUT_J_ENABLE,
    output DATA_OUT
  );

endinterface

// File: rtl/model_matrix_buffer_ram.sv
// Frame storage: one write port, one synchronous read port with read enable.
// Contents are deliberately not reset.
module model_matrix_buffer_ram #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/model_matrix_stream_buffer.sv
// Elastic frame buffer: captures one SIZE_I x SIZE_J matrix from an I/J framed
// element stream and replays it row-major with stall backpressure.
module model_matrix_stream_buffer
  import model_algebra_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter int unsigned MAX_I        = 8,
  parameter int unsigned MAX_J        = 8
) (
  input logic                     CLK,
  input logic                     RST,
  model_matrix_stream_buffer_if.slave bus
);

  localparam int unsigned IW    = clog2(MAX_I);
  localparam int unsigned JW    = clog2(MAX_J);
  localparam int unsigned DEPTH = MAX_I * MAX_J;
  localparam int unsigned AW    = clog2(DEPTH);

  localparam logic [DATA_SIZE-1:0] D_ONE = DATA_SIZE'(ONE_DATA);

  if (CONTROL_SIZE < $bits(state_t)) begin : g_control_width_check
    $error("CONTROL_SIZE too narrow to hold the buffer state code");
  end

  state_t               state;
  logic [IW-1:0]        i_cnt;
  logic [JW-1:0]        j_cnt;
  logic [DATA_SIZE-1:0] size_i;
  logic [DATA_SIZE-1:0] size_j;

  logic                 ready_q;
  logic                 error_q;
  logic                 out_i_q;
  logic                 out_j_q;
  logic                 out_last_q;
  logic [DATA_SIZE-1:0] data_out_q;

  // Read stage: tags travelling alongside the RAM read register.
  logic                 rd_valid_q;
  logic                 rd_first_q;
  logic                 rd_last_q;
  logic                 rd_done_q;

  logic                 i_last;
  logic                 j_last;
  logic                 size_bad;
  logic                 wr_en;
  logic                 rd_en;
  logic [AW-1:0]        addr;
  logic [DATA_SIZE-1:0] ram_rd_data;

  always_comb begin
    i_last   = (DATA_SIZE'(i_cnt) == size_i - D_ONE);
    j_last   = (DATA_SIZE'(j_cnt) == size_j - D_ONE);
    size_bad = (bus.SIZE_I_IN == '0) || (bus.SIZE_J_IN == '0) ||
               (bus.SIZE_I_IN > DATA_SIZE'(MAX_I)) ||
               (bus.SIZE_J_IN > DATA_SIZE'(MAX_J));
    addr     = AW'(i_cnt) * AW'(MAX_J) + AW'(j_cnt);
    wr_en    = (state == CAPTURE) && bus.DATA_IN_J_ENABLE;
    rd_en    = (state == EMIT) && !bus.DATA_OUT_STALL && !rd_done_q;
  end

  model_matrix_buffer_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (addr),
    .wr_data (bus.DATA_IN),
    .rd_en   (rd_en),
    .rd_addr (addr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      i_cnt      <= '0;
      j_cnt      <= '0;
      size_i     <= '0;
      size_j     <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      out_i_q    <= 1'b0;
      out_j_q    <= 1'b0;
      out_last_q <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            size_i  <= bus.SIZE_I_IN;
            size_j  <= bus.SIZE_J_IN;
            i_cnt   <= '0;
            j_cnt   <= '0;
            error_q <= size_bad;
            ready_q <= size_bad;
            state   <= size_bad ? DONE : CAPTURE;
          end
        end

        CAPTURE: begin
          if (bus.DATA_IN_J_ENABLE) begin
            if (bus.DATA_IN_I_ENABLE != (j_cnt == '0)) begin
              error_q <= 1'b1;
            end
            if (j_last) begin
              j_cnt <= '0;
              if (i_last) begin
                i_cnt      <= '0;
                rd_valid_q <= 1'b0;
                rd_done_q  <= 1'b0;
                out_last_q <= 1'b0;
                state      <= EMIT;
              end else begin
                i_cnt <= i_cnt + IW'(1);
              end
            end else begin
              j_cnt <= j_cnt + JW'(1);
            end
          end
        end

        EMIT: begin
          // Read stage and output stage advance together, so a stall freezes
          // the whole two-deep pipeline without losing the prefetched element.
          if (!bus.DATA_OUT_STALL) begin
            rd_valid_q <= !rd_done_q;
            rd_first_q <= (j_cnt == '0);
            rd_last_q  <= i_last && j_last;
            if (!rd_done_q) begin
              if (j_last) begin
                j_cnt <= '0;
                if (i_last) begin
                  rd_done_q <= 1'b1;
                end else begin
                  i_cnt <= i_cnt + IW'(1);
                end
              end else begin
                j_cnt <= j_cnt + JW'(1);
              end
            end

            if (out_last_q) begin
              out_i_q    <= 1'b0;
              out_j_q    <= 1'b0;
              out_last_q <= 1'b0;
              ready_q    <= 1'b1;
              state      <= DONE;
            end else begin
              out_j_q    <= rd_valid_q;
              out_i_q    <= rd_valid_q && rd_first_q;
              out_last_q <= rd_valid_q && rd_last_q;
              if (rd_valid_q) begin
                data_out_q <= ram_rd_data;
              end
            end
          end
        end

        DONE: begin
          i_cnt <= '0;
          j_cnt <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.READY             = ready_q;
  assign bus.ERROR             = error_q;
  assign bus.DATA_OUT_I_ENABLE = out_i_q;
  assign bus.DATA_OUT_J_ENABLE = out_j_q;
  assign bus.DATA_OUT          = data_out_q;

endmodule

// File: tb/tb_model_matrix_stream_buffer.sv
// Directed bench for model_matrix_stream_buffer: capture/replay timing, stall,
// rejected sizes, framing error, ignored START and mid-frame reset.
module tb_model_matrix_stream_buffer;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;

  model_matrix_stream_buffer_if #(.DATA_SIZE(64)) bus ();

  model_matrix_stream_buffer #(
    .DATA_SIZE    (64),
    .CONTROL_SIZE (4),
    .MAX_I        (8),
    .MAX_J        (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.READY), 64'd0);
    check({tag, "_jen"}, 64'(bus.DATA_OUT_J_ENABLE), 64'd0);
    check({tag, "_ien"}, 64'(bus.DATA_OUT_I_ENABLE), 64'd0);
  endtask

  task automatic start_frame(input logic [63:0] si, input logic [63:0] sj);
    bus.SIZE_I_IN = si;
    bus.SIZE_J_IN = sj;
    bus.START     = 1'b1;
    step();
    bus.START     = 1'b0;
  endtask

  // Stream values base, base+1, ... row-major; bad_k flips I_ENABLE on that element.
  task automatic feed(input int n_i, input int n_j, input logic [63:0] base, input int bad_k);
    for (int k = 0; k < n_i * n_j; k++) begin
      bus.DATA_IN          = base + 64'(k);
      bus.DATA_IN_J_ENABLE = 1'b1;
      bus.DATA_IN_I_ENABLE = ((k % n_j) == 0) ^ (k == bad_k);
      step();
    end
    bus.DATA_IN_J_ENABLE = 1'b0;
    bus.DATA_IN_I_ENABLE = 1'b0;
  endtask

  // Entered 1ns after the edge accepting the last element.
  task automatic expect_frame(input string name, input int n_i, input int n_j,
                              input logic [63:0] base, input int stall_k,
                              input int stall_len, input int start_k,
                              input logic exp_err);
    step();
    check({name, "_lat_jen"}, 64'(bus.DATA_OUT_J_ENABLE), 64'd0);
    for (int k = 0; k < n_i * n_j; k++) begin
      step();
      bus.START = 1'b0;
      check($sformatf("%s_data%0d", name, k), bus.DATA_OUT, base + 64'(k));
      check($sformatf("%s_jen%0d", name, k), 64'(bus.DATA_OUT_J_ENABLE), 64'd1);
      check($sformatf("%s_ien%0d", name, k), 64'(bus.DATA_OUT_I_ENABLE),
            64'((k % n_j) == 0));
      check($sformatf("%s_rdy%0d", name, k), 64'(bus.READY), 64'd0);
      if (k == stall_k) begin
        bus.DATA_OUT_STALL = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          step();
          check($sformatf("%s_hold%0d", name, s), bus.DATA_OUT, base + 64'(k));
          check($sformatf("%s_holdj%0d", name, s), 64'(bus.DATA_OUT_J_ENABLE), 64'd1);
          check($sformatf("%s_holdr%0d", name, s), 64'(bus.READY), 64'd0);
        end
        bus.DATA_OUT_STALL = 1'b0;
      end
      if (k == start_k) begin
        bus.SIZE_I_IN = 64'd1;
        bus.SIZE_J_IN = 64'd1;
        bus.START     = 1'b1;
      end
    end
    step();
    bus.START = 1'b0;
    check({name, "_ready"}, 64'(bus.READY), 64'd1);
    check({name, "_error"}, 64'(bus.ERROR), 64'(exp_err));
    check({name, "_done_jen"}, 64'(bus.DATA_OUT_J_ENABLE), 64'd0);
    check({name, "_done_ien"}, 64'(bus.DATA_OUT_I_ENABLE), 64'd0);
    step();
    check_idle_outputs({name, "_after"});
    check({name, "_err_sticky"}, 64'(bus.ERROR), 64'(exp_err));
    step();
    check_idle_outputs({name, "_after2"});
  endtask

  task automatic expect_reject(input string name, input logic [63:0] si, input logic [63:0] sj);
    start_frame(si, sj);
    check({name, "_ready"}, 64'(bus.READY), 64'd1);
    check({name, "_error"}, 64'(bus.ERROR), 64'd1);
    check({name, "_jen"}, 64'(bus.DATA_OUT_J_ENABLE), 64'd0);
    step();
    check_idle_outputs({name, "_after"});
    check({name, "_sticky"}, 64'(bus.ERROR), 64'd1);
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    RST                  = 1'b1;
    bus.START            = 1'b0;
    bus.DATA_IN_I_ENABLE = 1'b0;
    bus.DATA_IN_J_ENABLE = 1'b0;
    bus.DATA_OUT_STALL   = 1'b0;
    bus.SIZE_I_IN        = '0;
    bus.SIZE_J_IN        = '0;
    bus.DATA_IN          = '0;

    #3;
    check_idle_outputs("reset");
    check("reset_error", 64'(bus.ERROR), 64'd0);
    check("reset_data", bus.DATA_OUT, 64'd0);
    step();
    RST = 1'b0;
    step();

    // Stray elements while IDLE must be dropped and produce nothing.
    bus.DATA_IN = 64'hdead;
    bus.DATA_IN_J_ENABLE = 1'b1;
    step();
    bus.DATA_IN_J_ENABLE = 1'b0;
    step();
    check_idle_outputs("idle_drop");

    start_frame(64'd2, 64'd3);
    check("f1_err_clear", 64'(bus.ERROR), 64'd0);
    feed(2, 3, 64'd1, -1);
    expect_frame("f1", 2, 3, 64'd1, -1, 0, -1, 1'b0);

    start_frame(64'd2, 64'd2);
    feed(2, 2, 64'd10, -1);
    expect_frame("f2", 2, 2, 64'd10, 1, 3, -1, 1'b0);

    expect_reject("rej_i0", 64'd0, 64'd2);
    expect_reject("rej_j9", 64'd2, 64'd9);

    start_frame(64'd3, 64'd2);
    check("f3_err_clear", 64'(bus.ERROR), 64'd0);
    feed(3, 2, 64'd100, 1);
    expect_frame("f3", 3, 2, 64'd100, -1, 0, -1, 1'b1);

    start_frame(64'd2, 64'd2);
    check("f4_err_clear", 64'(bus.ERROR), 64'd0);
    feed(2, 2, 64'h20, -1);
    expect_frame("f4", 2, 2, 64'h20, -1, 0, 1, 1'b0);

    // Reset while the third element of a 4x4 frame is presented.
    start_frame(64'd4, 64'd4);
    feed(4, 4, 64'h100, -1);
    step();
    step();
    check("rst_e0", bus.DATA_OUT, 64'h100);
    step();
    step();
    check("rst_e2", bus.DATA_OUT, 64'h102);
    RST = 1'b1;
    #1;
    check_idle_outputs("rst_now");
    check("rst_now_data", bus.DATA_OUT, 64'd0);
    check("rst_now_error", 64'(bus.ERROR), 64'd0);
    step();
    step();
    RST = 1'b0;
    step();
    step();
    check_idle_outputs("rst_release");
    check("rst_release_data", bus.DATA_OUT, 64'd0);

    start_frame(64'd2, 64'd3);
    feed(2, 3, 64'h30, -1);
    expect_frame("f5", 2, 3, 64'h30, -1, 0, -1, 1'b0);

    start_frame(64'd8, 64'd8);
    feed(8, 8, 64'h1000, -1);
    expect_frame("fmax", 8, 8, 64'h1000, 40, 2, -1, 1'b0);

    start_frame(64'd1, 64'd1);
    feed(1, 1, 64'h77, -1);
    expect_frame("f1x1", 1, 1, 64'h77, -1, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
